ysyx_22041752_mul_iter: RTL and testbench

- Iterative radix-4 Booth multiplier for the EXE-stage MUL/MULH/MULHSU/MULHU/MULW ops.
- Downstream consumer of the Booth-2 partial-product selector: each cycle it presents a 3-bit multiplier window and the shifted multiplicand, then accumulates the returned partial product plus its +1 carry.
- Produces the full 2*DATA_WD product via a valid/ready handshake toward EXE/MEM.

---
 rtl/ysyx_22041752_mul_iter_pkg.sv | 10 +
 rtl/ysyx_22041752_booth2.sv | 20 ++
 rtl/ysyx_22041752_mul_iter.sv | 90 +++++++++
 tb/tb_ysyx_22041752_mul_iter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041752_mul_iter_pkg.sv
// ysyx_22041752_mul_iter_pkg: shared widths, step count and FSM encoding for the iterative multiplier.
package ysyx_22041752_mul_iter_pkg;
    localparam int RF_DATA_WD = 64;
    localparam int MUL_STEPS  = RF_DATA_WD / 2 + 1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/ysyx_22041752_booth2.sv
// ysyx_22041752_booth2: radix-4 Booth partial-product selector; negative digits return ~mag with carry c=1.
module ysyx_22041752_booth2 #(
    parameter int WD = 128
) (
    input  logic [WD-1:0] x,
    input  logic [2:0]    y,
    output logic [WD-1:0] p,
    output logic          c
);
    logic          one;
    logic          two;
    logic [WD-1:0] mag;
    always_comb begin
        one = y[1] ^ y[0];
        two = (y == 3'b011) | (y == 3'b100);
        mag = one ? x : two ? {x[WD-2:0], 1'b0} : '0;
        c   = y[2] & ~(y[1] & y[0]);
        p   = c ? ~mag : mag;
    end
endmodule

// File: rtl/ysyx_22041752_mul_iter.sv
// ysyx_22041752_mul_iter: iterative radix-4 Booth multiplier, 2*DATA_WD product over a valid/ready handshake.
// Define YSYX_22041752_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier windows are all zero-valued.
module ysyx_22041752_mul_iter
    import ysyx_22041752_mul_iter_pkg::*;
#(
    parameter int DATA_WD = RF_DATA_WD
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_WD-1:0]   in_a,
    input  logic [DATA_WD-1:0]   in_b,
    input  logic                 in_a_signed,
    input  logic                 in_b_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*DATA_WD-1:0] out_result
);
    localparam int PW = 2 * DATA_WD;
    localparam int YW = DATA_WD + 3;
    localparam int CW = $clog2(DATA_WD / 2 + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WD / 2);

    state_e          state_q, state_d;
    logic [PW-1:0]   x_q, x_d, acc_q, acc_d, pp;
    logic [YW-1:0]   y_q, y_d, y_shift;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pc, accept, busy, last, a_ext, b_ext;

    ysyx_22041752_booth2 #(.WD(PW)) u_booth2 (
        .x (x_q),
        .y (y_q[2:0]),
        .p (pp),
        .c (pc)
    );

    always_comb begin
        accept  = (state_q == IDLE) & in_valid & ~flush;
        busy    = state_q == BUSY;
        y_shift = {{2{y_q[YW-1]}}, y_q[YW-1:2]};
`ifdef YSYX_22041752_MUL_EARLY_EXIT_EN
        last    = (cnt_q == LAST) | (&y_shift) | ~(|y_shift);
`else
        last    = cnt_q == LAST;
`endif
    end

    always_comb begin
        state_d = flush                              ? IDLE :
                  accept                             ? BUSY :
                  (busy && last)                     ? DONE :
                  (state_q == DONE && out_ready)     ? IDLE : state_q;
    end

    always_comb begin
        in_ready   = state_q == IDLE;
        out_valid  = state_q == DONE;
        out_result = acc_q;
    end

    always_comb begin
        a_ext = in_a_signed & in_a[DATA_WD-1];
        b_ext = in_b_signed & in_b[DATA_WD-1];
        x_d   = accept ? {{DATA_WD{a_ext}}, in_a} : busy ? {x_q[PW-3:0], 2'b00} : x_q;
        y_d   = accept ? {b_ext, b_ext, in_b, 1'b0} : busy ? y_shift : y_q;
        acc_d = accept ? '0 : busy ? acc_q + pp + PW'(pc) : acc_q;
        cnt_d = accept ? '0 : busy ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ysyx_22041752_mul_iter.sv
// tb_ysyx_22041752_mul_iter: directed and randomized checks against a behavioural 128-bit product model.
module tb_ysyx_22041752_mul_iter;
    logic         clk = 0, resetn = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic         in_a_signed = 0, in_b_signed = 0;
    logic [63:0]  in_a = 0, in_b = 0;
    logic         in_ready, out_valid;
    logic [127:0] out_result;
    int           ntot = 0, npass = 0;

    ysyx_22041752_mul_iter dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_a_signed(in_a_signed), .in_b_signed(in_b_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b, input logic as, input logic bs);
        logic [127:0] ea, eb;
        ea = as ? {{64{a[63]}}, a} : {64'd0, a};
        eb = bs ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    function automatic int lat_model(input logic [63:0] b, input logic bs);
`ifdef YSYX_22041752_MUL_EARLY_EXIT_EN
        logic [66:0] y;
        int n;
        y = {{2{bs & b[63]}}, b, 1'b0};
        n = 0;
        do begin
            y = {y[66], y[66], y[66:2]};
            n++;
        end while (n < 33 && !(&y) && (|y));
        return n;
`else
        return 33;
`endif
    endfunction

    // Model: pending operation, its expected product and the cycle it becomes available
    logic         pending = 0;
    logic [127:0] exp_res = 0;
    int           cyc = 0, acc_cyc = 0, exp_lat = 33;
    logic         done_pre;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) pending = 0;
        else begin
            done_pre = pending && (cyc - acc_cyc >= exp_lat);
            cyc++;
            if (flush) pending = 0;
            else if (!pending && in_valid) begin
                pending = 1;
                exp_res = model(in_a, in_b, in_a_signed, in_b_signed);
                exp_lat = lat_model(in_b, in_b_signed);
                acc_cyc = cyc;
            end else if (done_pre && out_ready) pending = 0;
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            chk("in_ready", 128'(in_ready), 128'(!pending));
            chk("out_valid", 128'(out_valid), 128'(pending && (cyc - acc_cyc >= exp_lat)));
            if (out_valid && pending && (cyc - acc_cyc >= exp_lat))
                chk("out_result", out_result, exp_res);
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic as, input logic bs);
        @(negedge clk);
        in_a = a; in_b = b; in_a_signed = as; in_b_signed = bs; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        in_a_signed = 1'($urandom); in_b_signed = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) chk("done_timeout", 128'(out_valid), 128'd1);
    endtask

    task automatic release_out();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    localparam logic [127:0] M1 = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    localparam logic [127:0] M6 = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA;
`ifdef YSYX_22041752_MUL_EARLY_EXIT_EN
    localparam int LAT35 = 2;
`else
    localparam int LAT35 = 33;
`endif

    initial begin
        int lat;
        logic [127:0] held;
        logic seen;
        logic [63:0] a, b;
        #12 resetn = 1;
        @(negedge clk);
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_result", out_result, 128'd0);

        issue(64'd3, 64'd5, 0, 0);
        wait_done(lat);
        chk("u3x5", out_result, 128'd15);
        chk("u3x5_latency", 128'(lat), 128'(LAT35));
        release_out();

        issue('1, '1, 1, 1);
        wait_done(lat);
        chk("s_m1xm1", out_result, 128'd1);
        chk("s_m1xm1_mulh", {64'd0, out_result[127:64]}, 128'd0);
        release_out();

        issue('1, '1, 0, 0);
        wait_done(lat);
        chk("mulhu_max", out_result, M1);
        chk("mulhu_max_lat", 128'(lat), 128'd33);
        release_out();

        issue(-64'sd2, 64'd3, 1, 0);
        wait_done(lat);
        chk("su_m2x3", out_result, M6);
        release_out();

        issue(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 0, 1);
        wait_done(lat);
        held = out_result;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stable", out_result, held);
            chk("bp_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        chk("bp_result", held, model(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 0, 1));
        release_out();
        chk("bp_idle", 128'(in_ready), 128'd1);

        issue(64'd123, 64'h0123_4567_89AB_CDEF, 0, 0);
        repeat (4) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_in_ready", 128'(in_ready), 128'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("flush_no_valid", 128'(seen), 128'd0);
        issue(64'd7, 64'd6, 0, 0);
        wait_done(lat);
        chk("u7x6", out_result, 128'd42);
        release_out();

        issue(64'hDEAD_BEEF, 64'hCAFE_F00D_1234_5678, 1, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 resetn = 0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'd0);
        chk("arst_in_ready", 128'(in_ready), 128'd1);
        chk("arst_result", out_result, 128'd0);
        #4 resetn = 1;

        for (int k = 0; k < 40; k++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (k % 5 == 1) b = 64'($urandom_range(0, 255));
            if (k % 5 == 2) a = 64'h8000_0000_0000_0000;
            if (k % 5 == 3) b = '1;
            issue(a, b, 1'($urandom), 1'($urandom));
            wait_done(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_out();
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
